prefix_tree: RTL and testbench
==============================

// Module: prefix_tree
// PURPOSE
//  Pipelined Kogge-Stone parallel-prefix carry network for a carry-lookahead adder.
//  Takes per-bit generate/propagate vectors and returns per-bit carries.
//  Each carry is the group generate G[i:0] with carry-in = 0.
//  Sits between the adder's g/p pre-processing and its sum XOR stage.
//  Fully pipelined: one prefix level per register stage, one vector accepted every cycle.
// PARAMETERS
//  N   32   operand width in bits; N >= 2. L = $clog2(N) = number of prefix levels/stages.
// PORTS
//  clk        in   1   single clock; all state updates on posedge.
//  rst        in   1   asynchronous, active-low reset (asserted when 0).
//  in_valid   in   1   g/p are valid this cycle.
//  g          in   N   per-bit generate (g[i] = a[i] & b[i]).
//  p          in   N   per-bit propagate (p[i] = a[i] ^ b[i] or a[i] | b[i]).
//  c          out  N   carries: c[i] = carry out of bit i = G[i:0].
//  out_valid  out  1   c holds the result of an accepted input.
// BEHAVIOUR
//  - Level j (j=1..L), distance d=2^(j-1), for each bit i:
//      i >= d: Gj[i] = G(j-1)[i] | (P(j-1)[i] & G(j-1)[i-d]);  Pj[i] = P(j-1)[i] & P(j-1)[i-d]
//      i <  d: Gj[i] = G(j-1)[i];  Pj[i] = P(j-1)[i]  (pass-through)
//    Level 0 is the raw g/p inputs. c = GL.
//    Indices at or beyond the top level are never referenced; no wrap-around between bit 0 and bit N-1.
//  - Level 1 is computed combinationally from the g/p ports and registered.
//    Each later level is computed from the previous stage's registers and registered.
//  - The stage-L G register drives c directly. There is no combinational path from the inputs to c.
//  - Latency: an input presented with in_valid=1 before posedge t is visible on c/out_valid after posedge t+L-1.
//    That is L cycles: N=8 -> 3, N=32 -> 5.
//  - A valid bit travels alongside each stage. out_valid is the valid bit of stage L.
//  - No back-pressure and no stall: throughput is 1 vector per cycle.
//    Back-to-back inputs emerge back-to-back, in order.
//  - in_valid=0 inserts a bubble: the stage still captures the g/p data, but its valid bit is 0.
//    out_valid is 0 for the matching cycle.
//  - When out_valid=0, c is don't-care for checking, but must still be a deterministic function of past inputs (no X after reset).
//  - Reset (rst=0, async): all valid bits and all G/P stage registers clear to 0 immediately, so c=0 and out_valid=0.
//    In-flight data is discarded.
//    After release, the first valid output appears L cycles after the first in_valid=1.
//  - The width of c always equals N; no carry-out beyond bit N-1 is produced.
// TESTING
//  (N=8, L=3)
//  1. g=0x01, p=0xFE -> c=0xFF; out_valid high exactly 3 cycles after the input cycle.
//  2. g=0x80, p=0x00 -> c=0x80. Then g=0x00, p=0xFF -> c=0x00 (propagate alone creates no carry).
//  3. g=0x04, p=0x38 -> c=0x3C. Then g=0x11, p=0xEE -> c=0xFF.
//  4. 100 random back-to-back vectors checked against a ripple model.
//     Requires c[i] = g[i] | p[i]&c[i-1], with c[-1]=0, and exactly one out_valid per input, in order.
//  5. in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 three cycles later; bubble cycle not scored.
//  6. Drive rst=0 mid-stream while two vectors are in flight.
//     -> c=0 and out_valid=0 immediately; no stale result after release; the new stream is correct.

Source files
------------

// File: rtl/prefix_tree.sv
// rtl/prefix_tree.sv - pipelined Kogge-Stone carry prefix network
//
// Purpose:
//   Turns per-bit generate/propagate vectors into per-bit carries
//   c[i] = G[i:0] (carry-in 0).
//   There is one prefix level per register stage, so L = $clog2(N) stages in total.
//   A new vector is accepted every cycle. There is no stall and no back-pressure.
//
// Ports:
//   clk        clock, posedge
//   rst        asynchronous active-low reset; clears all stage state
//   in_valid   g/p carry a real vector this cycle
//   g [N-1:0]  per-bit generate
//   p [N-1:0]  per-bit propagate
//   c [N-1:0]  carries, driven straight from the last stage register
//   out_valid  c holds the result of an accepted input

module prefix_tree #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  output logic [N-1:0] c,
  output logic         out_valid
);

  localparam int L  = $clog2(N);
  // The last level's propagate output is never consumed, so only
  // levels 1..L-1 keep a P register.
  localparam int LP = (L > 1) ? L - 1 : 1;

  logic [N-1:0] g_q   [L];   // g_q[j] holds level j+1
  logic [N-1:0] p_q   [LP];
  logic [L-1:0] v_q;         // valid bit travelling with each stage

  logic [N-1:0] g_src [L];   // inputs to the level computed into g_q[j]
  logic [N-1:0] p_src [L];
  logic [N-1:0] g_nxt [L];
  logic [N-1:0] p_nxt [LP];

  always_comb begin
    g_src = '{default: '0};
    p_src = '{default: '0};
    g_nxt = '{default: '0};
    p_nxt = '{default: '0};

    g_src[0] = g;
    p_src[0] = p;
    for (int j = 1; j < L; j++) begin
      g_src[j] = g_q[j-1];
      p_src[j] = p_q[j-1];
    end

    for (int j = 0; j < L; j++) begin
      // Left shift by the level distance zero-fills the low bits.
      // This gives the pass-through for bits below the distance,
      // and no wrap-around from bit N-1 back to bit 0.
      g_nxt[j] = g_src[j] | (p_src[j] & (g_src[j] << (1 << j)));
    end
    for (int j = 0; j < L - 1; j++) begin
      // Inverting before and after the shift keeps P unchanged
      // for bits below the distance.
      p_nxt[j] = p_src[j] & ~((~p_src[j]) << (1 << j));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < L; j++) g_q[j] <= '0;
      for (int j = 0; j < LP; j++) p_q[j] <= '0;
      v_q <= '0;
    end else begin
      // Data is captured even on bubbles so c stays a
      // deterministic function of past inputs.
      for (int j = 0; j < L; j++) g_q[j] <= g_nxt[j];
      for (int j = 0; j < L - 1; j++) p_q[j] <= p_nxt[j];
      v_q[0] <= in_valid;
      for (int j = 1; j < L; j++) v_q[j] <= v_q[j-1];
    end
  end

  assign c         = g_q[L-1];
  assign out_valid = v_q[L-1];

endmodule

// File: tb/tb_prefix_tree.sv
// tb/tb_prefix_tree.sv - scoreboard bench for prefix_tree (N=8)

module tb_prefix_tree;

  localparam int N   = 8;
  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic         out_valid;

  typedef struct {
    logic [N-1:0] c;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  prefix_tree #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .g         (g),
    .p         (p),
    .c         (c),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Carry chain: each bit either generates a carry
  // or passes on the carry from the bit below.
  function automatic logic [N-1:0] ripple(input logic [N-1:0] gg, input logic [N-1:0] pp);
    logic [N-1:0] r;
    logic         cin;
    cin = 1'b0;
    for (int i = 0; i < N; i++) begin
      r[i] = gg[i] | (pp[i] & cin);
      cin  = r[i];
    end
    return r;
  endfunction

  // Drive one cycle of input; a valid vector pushes its expected carries
  // and the cycle on which they must appear.
  task automatic issue(input logic v, input logic [N-1:0] gg, input logic [N-1:0] pp,
                       input logic [N-1:0] exp_c);
    exp_t e;
    in_valid = v;
    g        = gg;
    p        = pp;
    if (v) begin
      e.c   = exp_c;
      e.cyc = cyc + LAT;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rand(input logic v);
    logic [N-1:0] gg, pp;
    gg = N'($urandom);
    pp = N'($urandom);
    issue(v, gg, pp, ripple(gg, pp));
  endtask

  // Monitor: pops one expectation per out_valid and checks data and timing.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: c=%h at cycle %0d with nothing expected", c, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (c !== e.c || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: c=%h at cycle %0d, expected c=%h at cycle %0d",
                   c, cyc, e.c, e.cyc);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (c !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: c=%h out_valid=%b, expected c=00 out_valid=0", name, c, out_valid);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results never appeared, expected 0 outstanding", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    g        = '0;
    p        = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    issue(1'b1, 8'h01, 8'hFE, 8'hFF);
    issue(1'b1, 8'h80, 8'h00, 8'h80);
    issue(1'b1, 8'h00, 8'hFF, 8'h00);
    issue(1'b1, 8'h04, 8'h38, 8'h3C);
    issue(1'b1, 8'h11, 8'hEE, 8'hFF);
    issue(1'b1, 8'hFF, 8'h00, 8'hFF);
    issue(1'b1, 8'h00, 8'h00, 8'h00);
    issue(1'b0, 8'h00, 8'h00, 8'h00);
    drain("directed_drain");

    // Bubble pattern 1,0,1
    issue(1'b1, 8'h01, 8'hFF, 8'hFF);
    issue(1'b0, 8'hFF, 8'hFF, 8'h00);
    issue(1'b1, 8'h02, 8'h0C, 8'h0E);
    issue(1'b0, 8'h00, 8'h00, 8'h00);
    drain("bubble_drain");

    // 100 random back-to-back vectors
    for (int i = 0; i < 100; i++) issue_rand(1'b1);
    issue(1'b0, 8'h00, 8'h00, 8'h00);
    drain("random_drain");

    // Random traffic with random bubbles
    for (int i = 0; i < 60; i++) issue_rand(1'($urandom_range(0, 1)));
    issue(1'b0, 8'h00, 8'h00, 8'h00);
    drain("bubble_rand_drain");

    // Reset while two vectors are in flight
    issue_rand(1'b1);
    issue_rand(1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    q.delete();
    @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) issue_rand(1'b1);
    issue(1'b0, 8'h00, 8'h00, 8'h00);
    drain("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
